// File: rtl/onchip_mem_bist_master_if.sv
// Avalon-MM slave-port bundle of the single-port on-chip memory, seen from the BIST master.
// Read latency is one cycle: readdata is valid in the cycle after the address is presented.
interface onchip_mem_bist_master_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                clken;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/onchip_mem_bist_master.sv
// Fill/verify BIST master for the on-chip memory: one word per cycle, done N+1 (fill) / N+2 (check).
// No backpressure: the memory accepts every cycle; abort stops the bus on the following cycle.
module onchip_mem_bist_master #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 97500
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                mode,
    input  logic                      pattern_sel,
    input  logic [31:0]               seed,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         num_words,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      range_err,
    output logic [ADDR_W-1:0]         err_count,
    output logic [ADDR_W-1:0]         first_err_addr,
    output logic [DATA_W-1:0]         first_err_data,
    onchip_mem_bist_master_if.master  mem
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic              r_sel;
    logic              r_chain;
    logic [31:0]       r_seed;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_num;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       pat;
    logic [31:0]       cur_exp;
    logic              rd_pend;
    logic [31:0]       rd_exp;
    logic [ADDR_W-1:0] rd_addr;

    function automatic logic [31:0] pat_next(input logic sel, input logic [31:0] p);
        return sel ? {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]} : p + 32'd1;
    endfunction

    // An all-zero LFSR state would lock up, so seed 0 starts from 1.
    function automatic logic [31:0] pat_first(input logic sel, input logic [31:0] s);
        return (sel && s == 32'd0) ? 32'd1 : s;
    endfunction

    logic [31:0] req_first;
    logic [31:0] lat_first;
    logic        range_bad;
    logic        req_fill;
    logic        cmp_hit;

    assign req_first = pat_first(pattern_sel, seed);
    assign lat_first = pat_first(r_sel, r_seed);
    assign range_bad = ({1'b0, base_addr} + {1'b0, num_words}) > (ADDR_W+1)'(DEPTH);
    assign req_fill  = (mode == 2'd0) || (mode == 2'd2);
    // A read still in flight when abort arrives is thrown away rather than compared.
    assign cmp_hit   = rd_pend && !abort && (mem.readdata != DATA_W'(rd_exp));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            range_err      <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            mem.address    <= '0;
            mem.byteenable <= '0;
            mem.chipselect <= 1'b0;
            mem.write      <= 1'b0;
            mem.writedata  <= '0;
            mem.clken      <= 1'b0;
            r_sel          <= 1'b0;
            r_chain        <= 1'b0;
            r_seed         <= '0;
            r_base         <= '0;
            r_num          <= '0;
            cnt            <= '0;
            pat            <= '0;
            cur_exp        <= '0;
            rd_pend        <= 1'b0;
            rd_exp         <= '0;
            rd_addr        <= '0;
        end else begin
            mem.clken      <= 1'b1;
            done           <= 1'b0;
            mem.chipselect <= 1'b0;
            mem.write      <= 1'b0;
            mem.byteenable <= '0;

            // Compare pipeline: the read on the bus this cycle returns data next cycle.
            rd_pend <= mem.chipselect && !mem.write && !abort;
            rd_exp  <= cur_exp;
            rd_addr <= mem.address;
            if (cmp_hit) begin
                err_count <= err_count + ADDR_W'(1);
                if (err_count == '0) begin
                    first_err_addr <= rd_addr;
                    first_err_data <= mem.readdata;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_sel          <= pattern_sel;
                        r_chain        <= (mode == 2'd2);
                        r_seed         <= seed;
                        r_base         <= base_addr;
                        r_num          <= num_words;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        pass           <= 1'b0;
                        range_err      <= 1'b0;
                        if (range_bad) begin
                            range_err <= 1'b1;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else if (num_words == '0) begin
                            pass  <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            busy           <= 1'b1;
                            cnt            <= ADDR_W'(1);
                            pat            <= pat_next(pattern_sel, req_first);
                            cur_exp        <= req_first;
                            mem.address    <= base_addr;
                            mem.chipselect <= 1'b1;
                            mem.byteenable <= '1;
                            mem.write      <= req_fill;
                            mem.writedata  <= DATA_W'(req_first);
                            state          <= req_fill ? S_WRITE : S_READ;
                        end
                    end
                end

                S_WRITE, S_READ: begin
                    if (abort) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        state <= S_DONE;
                    end else if (cnt != r_num) begin
                        mem.address    <= r_base + cnt;
                        mem.chipselect <= 1'b1;
                        mem.byteenable <= '1;
                        mem.write      <= (state == S_WRITE);
                        mem.writedata  <= DATA_W'(pat);
                        cur_exp        <= pat;
                        pat            <= pat_next(r_sel, pat);
                        cnt            <= cnt + ADDR_W'(1);
                    end else if (state == S_READ) begin
                        state <= S_DRAIN;
                    end else if (r_chain) begin
                        // Verify pass restarts the generator so it reproduces the fill sequence.
                        mem.address    <= r_base;
                        mem.chipselect <= 1'b1;
                        mem.byteenable <= '1;
                        cur_exp        <= lat_first;
                        pat            <= pat_next(r_sel, lat_first);
                        cnt            <= ADDR_W'(1);
                        state          <= S_READ;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DRAIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= !abort && (err_count == '0) && !cmp_hit;
                    state <= S_DONE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/onchip_mem_bist_master.md
# onchip_mem_bist_master

Avalon-MM master that fills and/or verifies a region of the 32-bit single-port on-chip memory. It drives the memory's slave port (address, byteenable, chipselect, write, writedata, clken) and checks returned readdata against a regenerated pattern. It sits beside the Nios II data master behind the fabric arbiter and is used for bring-up, post-configuration memory test and bulk initialisation.

## Interface
Parameters:
- ADDR_W, 17, word-address width of the memory
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 97500, number of valid words

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  terminate current operation
- mode  in  2  0 = fill, 1 = check, 2 = fill then check, 3 = reserved (treated as 1)
- pattern_sel  in  1  0 = incrementing (seed + offset), 1 = LFSR
- seed  in  32  pattern seed
- base_addr  in  ADDR_W  first word address
- num_words  in  ADDR_W  region length in words
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  last operation completed with zero errors, no abort, no range error
- range_err  out  1  last request rejected: base_addr + num_words > DEPTH
- err_count  out  ADDR_W  mismatching words in last check
- first_err_addr  out  ADDR_W  address of first mismatch
- first_err_data  out  DATA_W  readdata of first mismatch
- mem_address  out  ADDR_W  to memory address
- mem_byteenable  out  DATA_W/8  always all-ones when chipselect is high
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_writedata  out  DATA_W  to memory writedata
- mem_clken  out  1  to memory clken
- mem_readdata  in  DATA_W  from memory readdata

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: start=1 latches all request inputs, clears err_count/first_err_*/pass/range_err, asserts busy. Range check (computed ADDR_W+1 bits wide) failing -> DONE with range_err=1, no bus activity. num_words=0 -> DONE, pass=1. Else mode 0/2 -> WRITE, mode 1/3 -> READ.
- WRITE: one word per cycle, chipselect=write=1, byteenable all-ones, address base+i, data = pattern(i). After word N-1: mode 0 -> DONE, mode 2 -> READ with generator reseeded.
- READ: one read per cycle, chipselect=1, write=0. After address N-1 -> DRAIN (chipselect=0) to compare final word.
- Compare: readdata in cycle after address issue checked against pattern delayed one stage; mismatch increments err_count, first mismatch captures address and data.
- DONE: done=1 one cycle, busy=0, pass=(err_count==0 and not aborted and not range_err); -> IDLE.
- Pattern 0: seed + i, 32-bit wrap. Pattern 1: 32-bit Fibonacci LFSR, next = {l[30:0], l[31]^l[21]^l[1]^l[0]}, word 0 = seed (seed 0 substituted by 1), one step per word.
- abort in WRITE/READ/DRAIN: chipselect deasserts next cycle, in-flight read discarded, -> DONE with pass=0; err_count keeps compares already made. abort in IDLE ignored.
- start while busy ignored. Results held until next accepted start.

## Timing
- Reset values: all outputs 0 (mem_clken 0); mem_clken=1 from first cycle after reset release.
- All outputs registered. Cycle k = k-th cycle after the edge sampling start.
- Fill: word i on bus in cycle i+1; done in cycle N+1.
- Check: address i in cycle i+1, readdata sampled at end of cycle i+2; DRAIN cycle N+1; done in cycle N+2.
- Fill+check: writes cycles 1..N, reads N+1..2N, DRAIN 2N+1, done 2N+2.
- Range error / N=0: done in cycle 1.
- busy high from cycle 1 through cycle before done; low in done cycle.
- reset_n low mid-operation: chipselect/write drop immediately (asynchronous), state IDLE, results cleared.

## Test plan
- Fill, pattern 0, seed 0x10000000, base 0x100, N=4 -> writes 0x10000000..0x10000003 to 0x100..0x103 cycles 1..4, done cycle 5, pass=1.
- Check same region with memory model word 0x102 corrupted to 0xDEADBEEF -> err_count=1, first_err_addr=0x102, first_err_data=0xDEADBEEF, pass=0, done cycle 6.
- Fill+check, pattern 1, seed 0, base 0, N=16 -> word 0 = 0x00000001, word 1 = 0x00000003, pass=1, done cycle 34.
- base 97499, N=2 -> range_err=1, no chipselect, done cycle 1; N=0 -> pass=1, done cycle 1.
- Abort in cycle 3 of N=10 fill -> chipselect low from cycle 4, done cycle 4, pass=0; start during busy ignored.
- reset_n low during READ -> outputs 0 same cycle, next start runs normally.
